bomb_scheduler: RTL and testbench

Owns the bomb lifecycle for both players: drop acceptance, fuse timing, explosion and cooldown. It arbitrates the single shared blast unit, so only one explosion is active at a time, and it triggers chain reactions. It also computes blast damage and maintains both players' heart counters. It sits between the two player movement blocks (drop requests, positions in) and the renderer / player collision logic (bomb, blast, heart outputs).

---
 rtl/bomb_scheduler_if.sv | 27 ++
 rtl/bomb_scheduler.sv | 174 +++++++++++++++++
 tb/tb_bomb_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bomb_scheduler_if.sv
// Bus between the player movement blocks, the bomb scheduler and the renderer / collision logic.
// The scheduler takes the slave side; whoever drives drops and positions takes the master side.
interface bomb_scheduler_if;
   logic       drop1, drop2;
   logic [9:0] user1X, user1Y, user2X, user2Y;
   logic [9:0] bomb1X, bomb1Y, bomb2X, bomb2Y;
   logic       bomb1_on, bomb2_on;
   logic [9:0] blastX0, blastY0, blastX1, blastY1;
   logic       blast_on, blast_owner;
   logic       hit1, hit2;
   logic [2:0] heart1, heart2;
   logic       game_over;

   modport master (
      output drop1, drop2, user1X, user1Y, user2X, user2Y,
      input  bomb1X, bomb1Y, bomb2X, bomb2Y, bomb1_on, bomb2_on,
             blastX0, blastY0, blastX1, blastY1, blast_on, blast_owner,
             hit1, hit2, heart1, heart2, game_over
   );

   modport slave (
      input  drop1, drop2, user1X, user1Y, user2X, user2Y,
      output bomb1X, bomb1Y, bomb2X, bomb2Y, bomb1_on, bomb2_on,
             blastX0, blastY0, blastX1, blastY1, blast_on, blast_owner,
             hit1, hit2, heart1, heart2, game_over
   );
endinterface

// File: rtl/bomb_scheduler.sv
// Two-player bomb lifecycle: drop, fuse, shared blast unit with round-robin arbitration,
// chain reactions, blast damage and heart counters.
module bomb_scheduler #(
   parameter int FUSE_FRAMES  = 60,
   parameter int BLAST_FRAMES = 20,
   parameter int COOL_FRAMES  = 30,
   parameter int BOMB_S       = 16,
   parameter int BLAST_R      = 24,
   parameter int HEARTS_INIT  = 3,
   parameter int USER_W       = 16,
   parameter int USER_H       = 25
) (
   input logic             frame_clk,
   input logic             Reset,
   bomb_scheduler_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ARMED, PENDING, EXPLODE, COOLDOWN} state_t;

   localparam logic [7:0]  FUSE_LOAD  = 8'(FUSE_FRAMES - 1);
   localparam logic [7:0]  BLAST_LOAD = 8'(BLAST_FRAMES - 1);
   localparam logic [7:0]  COOL_LOAD  = 8'(COOL_FRAMES - 1);
   localparam logic [10:0] SIDE       = 11'(BOMB_S - 1);
   localparam logic [10:0] REACH      = 11'(BLAST_R);
   localparam logic [10:0] USER_DX    = 11'(USER_W - 1);
   localparam logic [10:0] USER_DY    = 11'(USER_H - 1);
   localparam logic [10:0] X_MAX      = 11'd639;
   localparam logic [10:0] Y_MAX      = 11'd479;

   state_t      state  [2];
   logic [7:0]  count  [2];
   logic [9:0]  bomb_x [2];
   logic [9:0]  bomb_y [2];
   logic [2:0]  heart  [2];
   logic [1:0]  drop_prev;
   logic        rr_next;
   logic [1:0]  hit;
   logic        game_over;

   logic [1:0]  drop, pending, exploding, grant, chain, hit_now;
   logic [9:0]  user_x [2];
   logic [9:0]  user_y [2];
   logic        owner, blast_on, damage_frame;
   logic [10:0] own_x, own_y, box_x0, box_x1, box_y0, box_y1;

   function automatic logic overlaps(input logic [10:0] a_x0, a_x1, a_y0, a_y1,
                                     input logic [10:0] b_x0, b_x1, b_y0, b_y1);
      return (a_x0 <= b_x1) && (a_x1 >= b_x0) && (a_y0 <= b_y1) && (a_y1 >= b_y0);
   endfunction

   // Blast box of whichever bomb holds the blast unit, arbitration and damage/chain detection
   always_comb begin
      drop      = {bus.drop2, bus.drop1};
      user_x[0] = bus.user1X;
      user_y[0] = bus.user1Y;
      user_x[1] = bus.user2X;
      user_y[1] = bus.user2Y;
      pending   = '0;
      exploding = '0;
      chain     = '0;
      hit_now   = '0;
      for (int i = 0; i < 2; i++) begin
         pending[i]   = (state[i] == PENDING);
         exploding[i] = (state[i] == EXPLODE);
      end
      blast_on = |exploding;
      owner    = exploding[1];
      own_x    = {1'b0, bomb_x[owner]};
      own_y    = {1'b0, bomb_y[owner]};
      box_x0   = (own_x >= REACH) ? own_x - REACH : 11'd0;
      box_y0   = (own_y >= REACH) ? own_y - REACH : 11'd0;
      box_x1   = (own_x + SIDE + REACH > X_MAX) ? X_MAX : own_x + SIDE + REACH;
      box_y1   = (own_y + SIDE + REACH > Y_MAX) ? Y_MAX : own_y + SIDE + REACH;

      grant = 2'b00;
      if (!blast_on)
         grant = (&pending) ? (rr_next ? 2'b10 : 2'b01) : pending;

      // Damage is judged only while the blast counter still holds its load value
      damage_frame = blast_on && (count[owner] == BLAST_LOAD);
      for (int i = 0; i < 2; i++) begin
         chain[i] = (state[i] == ARMED) && exploding[i ^ 1] &&
                    overlaps({1'b0, bomb_x[i]}, {1'b0, bomb_x[i]} + SIDE,
                             {1'b0, bomb_y[i]}, {1'b0, bomb_y[i]} + SIDE,
                             box_x0, box_x1, box_y0, box_y1);
         hit_now[i] = damage_frame &&
                      overlaps({1'b0, user_x[i]}, {1'b0, user_x[i]} + USER_DX,
                               {1'b0, user_y[i]}, {1'b0, user_y[i]} + USER_DY,
                               box_x0, box_x1, box_y0, box_y1);
      end
   end

   // Per-player bomb FSMs, round-robin pointer and heart bookkeeping
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 2; i++) begin
            state[i]  <= IDLE;
            count[i]  <= '0;
            bomb_x[i] <= '0;
            bomb_y[i] <= '0;
            heart[i]  <= 3'(HEARTS_INIT);
         end
         drop_prev <= '0;
         rr_next   <= 1'b0;
         hit       <= '0;
         game_over <= 1'b0;
      end else begin
         drop_prev <= drop;
         hit       <= hit_now;
         game_over <= game_over || (heart[0] == 3'd0) || (heart[1] == 3'd0);
         // The pointer only moves when both bombs were contending
         if ((&pending) && (|grant))
            rr_next <= grant[0];
         for (int i = 0; i < 2; i++) begin
            if (hit_now[i] && (heart[i] != 3'd0))
               heart[i] <= heart[i] - 3'd1;
            case (state[i])
               IDLE: begin
                  if (drop[i] && !drop_prev[i] && !game_over) begin
                     state[i]  <= ARMED;
                     count[i]  <= FUSE_LOAD;
                     bomb_x[i] <= user_x[i];
                     bomb_y[i] <= user_y[i];
                  end
               end
               ARMED: begin
                  if (chain[i] || (count[i] == 8'd0))
                     state[i] <= PENDING;
                  else
                     count[i] <= count[i] - 8'd1;
               end
               PENDING: begin
                  if (grant[i]) begin
                     state[i] <= EXPLODE;
                     count[i] <= BLAST_LOAD;
                  end
               end
               EXPLODE: begin
                  if (count[i] == 8'd0) begin
                     state[i] <= COOLDOWN;
                     count[i] <= COOL_LOAD;
                  end else begin
                     count[i] <= count[i] - 8'd1;
                  end
               end
               COOLDOWN: begin
                  if (count[i] == 8'd0)
                     state[i] <= IDLE;
                  else
                     count[i] <= count[i] - 8'd1;
               end
               default: state[i] <= IDLE;
            endcase
         end
      end
   end

   assign bus.bomb1X      = bomb_x[0];
   assign bus.bomb1Y      = bomb_y[0];
   assign bus.bomb2X      = bomb_x[1];
   assign bus.bomb2Y      = bomb_y[1];
   assign bus.bomb1_on    = (state[0] == ARMED) || (state[0] == PENDING);
   assign bus.bomb2_on    = (state[1] == ARMED) || (state[1] == PENDING);
   assign bus.blast_on    = blast_on;
   assign bus.blast_owner = owner;
   assign bus.blastX0     = blast_on ? box_x0[9:0] : 10'd0;
   assign bus.blastY0     = blast_on ? box_y0[9:0] : 10'd0;
   assign bus.blastX1     = blast_on ? box_x1[9:0] : 10'd0;
   assign bus.blastY1     = blast_on ? box_y1[9:0] : 10'd0;
   assign bus.hit1        = hit[0];
   assign bus.hit2        = hit[1];
   assign bus.heart1      = heart[0];
   assign bus.heart2      = heart[1];
   assign bus.game_over   = game_over;
endmodule

// File: tb/tb_bomb_scheduler.sv
// Bench for bomb_scheduler: directed scenarios plus a random phase, every frame compared
// against an event-time reference model (deadline frame numbers instead of counters).
module tb_bomb_scheduler;
   localparam int FUSE    = 60;
   localparam int BLAST   = 20;
   localparam int COOL    = 30;
   localparam int BOMB_S  = 16;
   localparam int BLAST_R = 24;
   localparam int USER_W  = 16;
   localparam int USER_H  = 25;
   localparam int HEARTS  = 3;

   logic frame_clk = 1'b0;
   logic Reset;
   int   checks = 0;
   int   errors = 0;

   bomb_scheduler_if bus ();

   bomb_scheduler dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .bus       (bus)
   );

   always #5 frame_clk = ~frame_clk;

   // Reference model: edge numbers at which each bomb changes phase
   int edge_num;
   bit m_live [2];
   bit m_pend [2];
   bit m_cool [2];
   int m_fuse_edge [2];
   int m_cool_end [2];
   int m_bomb_x [2];
   int m_bomb_y [2];
   bit m_prev_drop [2];
   int m_heart [2];
   bit m_hit [2];
   int m_owner;
   int m_blast_start;
   int m_blast_end;
   int m_tie;
   bit m_over;

   function automatic int lo_edge(input int p);
      return (p >= BLAST_R) ? p - BLAST_R : 0;
   endfunction

   function automatic int hi_edge(input int p, input int lim);
      return (p + BOMB_S - 1 + BLAST_R > lim) ? lim : p + BOMB_S - 1 + BLAST_R;
   endfunction

   function automatic bit rect_hit(input int ax0, ax1, ay0, ay1, bx0, bx1, by0, by1);
      return (ax0 <= bx1) && (ax1 >= bx0) && (ay0 <= by1) && (ay1 >= by0);
   endfunction

   task automatic modelReset();
      edge_num = 0;
      for (int i = 0; i < 2; i++) begin
         m_live[i] = 0; m_pend[i] = 0; m_cool[i] = 0;
         m_fuse_edge[i] = 0; m_cool_end[i] = 0;
         m_bomb_x[i] = 0; m_bomb_y[i] = 0;
         m_prev_drop[i] = 0; m_heart[i] = HEARTS; m_hit[i] = 0;
      end
      m_owner = -1; m_blast_start = 0; m_blast_end = 0; m_tie = 0; m_over = 0;
   endtask

   task automatic modelEdge();
      int f, g, x0, x1, y0, y1;
      bit ex, end_now, new_over;
      bit d [2];
      int ux [2];
      int uy [2];
      bit hit_now [2];
      bit pend_now [2];
      bit cool_done [2];
      bit drop_now [2];
      edge_num++;
      f = edge_num;
      d[0] = bus.drop1; d[1] = bus.drop2;
      ux[0] = int'(bus.user1X); uy[0] = int'(bus.user1Y);
      ux[1] = int'(bus.user2X); uy[1] = int'(bus.user2Y);
      ex = (m_owner >= 0);
      x0 = 0; x1 = 0; y0 = 0; y1 = 0;
      if (ex) begin
         x0 = lo_edge(m_bomb_x[m_owner]); x1 = hi_edge(m_bomb_x[m_owner], 639);
         y0 = lo_edge(m_bomb_y[m_owner]); y1 = hi_edge(m_bomb_y[m_owner], 479);
      end
      for (int i = 0; i < 2; i++) begin
         hit_now[i] = ex && (f == m_blast_start + 1) &&
                      rect_hit(ux[i], ux[i] + USER_W - 1, uy[i], uy[i] + USER_H - 1, x0, x1, y0, y1);
         pend_now[i] = m_live[i] && !m_pend[i] &&
                       ((f == m_fuse_edge[i]) ||
                        (ex && (m_owner != i) &&
                         rect_hit(m_bomb_x[i], m_bomb_x[i] + BOMB_S - 1,
                                  m_bomb_y[i], m_bomb_y[i] + BOMB_S - 1, x0, x1, y0, y1)));
         cool_done[i] = m_cool[i] && (f == m_cool_end[i]);
         drop_now[i]  = !m_live[i] && !m_cool[i] && !(ex && (m_owner == i)) &&
                        d[i] && !m_prev_drop[i] && !m_over;
      end
      g = -1;
      if (!ex) begin
         if (m_pend[0] && m_pend[1]) begin
            g = m_tie;
            m_tie = 1 - m_tie;
         end else if (m_pend[0]) g = 0;
         else if (m_pend[1]) g = 1;
      end
      end_now  = ex && (f == m_blast_end);
      new_over = m_over || (m_heart[0] == 0) || (m_heart[1] == 0);
      for (int i = 0; i < 2; i++) begin
         if (hit_now[i] && (m_heart[i] > 0)) m_heart[i]--;
         m_hit[i] = hit_now[i];
         if (pend_now[i]) m_pend[i] = 1;
         if (cool_done[i]) m_cool[i] = 0;
         if (drop_now[i]) begin
            m_live[i] = 1; m_pend[i] = 0; m_fuse_edge[i] = f + FUSE;
            m_bomb_x[i] = ux[i]; m_bomb_y[i] = uy[i];
         end
         m_prev_drop[i] = d[i];
      end
      if (end_now) begin
         m_cool[m_owner] = 1; m_cool_end[m_owner] = f + COOL; m_owner = -1;
      end
      if (g >= 0) begin
         m_live[g] = 0; m_pend[g] = 0; m_owner = g;
         m_blast_start = f; m_blast_end = f + BLAST;
      end
      m_over = new_over;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_num);
      end
   endtask

   task automatic checkOutput();
      int x0, x1, y0, y1;
      x0 = 0; x1 = 0; y0 = 0; y1 = 0;
      if (m_owner >= 0) begin
         x0 = lo_edge(m_bomb_x[m_owner]); x1 = hi_edge(m_bomb_x[m_owner], 639);
         y0 = lo_edge(m_bomb_y[m_owner]); y1 = hi_edge(m_bomb_y[m_owner], 479);
      end
      chk("bomb1_on", 32'(bus.bomb1_on), 32'(m_live[0]));
      chk("bomb2_on", 32'(bus.bomb2_on), 32'(m_live[1]));
      if (m_live[0]) begin
         chk("bomb1X", 32'(bus.bomb1X), m_bomb_x[0]);
         chk("bomb1Y", 32'(bus.bomb1Y), m_bomb_y[0]);
      end
      if (m_live[1]) begin
         chk("bomb2X", 32'(bus.bomb2X), m_bomb_x[1]);
         chk("bomb2Y", 32'(bus.bomb2Y), m_bomb_y[1]);
      end
      chk("blast_on", 32'(bus.blast_on), 32'(m_owner >= 0));
      chk("blast_owner", 32'(bus.blast_owner), 32'(m_owner == 1));
      chk("blastX0", 32'(bus.blastX0), x0);
      chk("blastY0", 32'(bus.blastY0), y0);
      chk("blastX1", 32'(bus.blastX1), x1);
      chk("blastY1", 32'(bus.blastY1), y1);
      chk("hit1", 32'(bus.hit1), 32'(m_hit[0]));
      chk("hit2", 32'(bus.hit2), 32'(m_hit[1]));
      chk("heart1", 32'(bus.heart1), m_heart[0]);
      chk("heart2", 32'(bus.heart2), m_heart[1]);
      chk("game_over", 32'(bus.game_over), 32'(m_over));
   endtask

   task automatic applyStimulus(input bit d1, input bit d2,
                                input int x1, input int y1, input int x2, input int y2);
      bus.drop1  = d1;
      bus.drop2  = d2;
      bus.user1X = 10'(x1);
      bus.user1Y = 10'(y1);
      bus.user2X = 10'(x2);
      bus.user2Y = 10'(y2);
   endtask

   task automatic runFrames(input int n);
      repeat (n) begin
         @(posedge frame_clk);
         modelEdge();
         #1;
         checkOutput();
      end
   endtask

   task automatic doReset();
      @(negedge frame_clk);
      Reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      #1;
      modelReset();
      checkOutput();
      @(negedge frame_clk);
      Reset = 1'b1;
   endtask

   initial begin
      int rx1, ry1, rx2, ry2;
      Reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      modelReset();

      $display("[TB] reset state and single uncontended bomb");
      doReset();
      chk("reset_heart1", 32'(bus.heart1), 32'd3);
      chk("reset_blast_on", 32'(bus.blast_on), 32'd0);
      applyStimulus(0, 0, 100, 200, 600, 440);
      runFrames(4);
      applyStimulus(1, 0, 100, 200, 600, 440);
      runFrames(1);
      chk("s1_armed", 32'(bus.bomb1_on), 32'd1);
      runFrames(60);
      chk("s1_pending_no_blast", 32'(bus.blast_on), 32'd0);
      runFrames(1);
      chk("s1_blast_on", 32'(bus.blast_on), 32'd1);
      chk("s1_box_x0", 32'(bus.blastX0), 32'd76);
      chk("s1_box_y0", 32'(bus.blastY0), 32'd176);
      chk("s1_box_x1", 32'(bus.blastX1), 32'd139);
      chk("s1_box_y1", 32'(bus.blastY1), 32'd239);
      runFrames(1);
      chk("s1_self_hit", 32'(bus.hit1), 32'd1);
      chk("s1_heart1_dec", 32'(bus.heart1), 32'd2);
      runFrames(1);
      chk("s1_hit_one_frame", 32'(bus.hit1), 32'd0);
      runFrames(18);
      chk("s1_blast_done", 32'(bus.blast_on), 32'd0);
      runFrames(218);
      chk("s1_held_no_rearm", 32'(bus.bomb1_on), 32'd0);
      applyStimulus(0, 0, 100, 200, 600, 440);
      runFrames(1);
      applyStimulus(1, 0, 100, 200, 600, 440);
      runFrames(1);
      chk("s1_second_drop", 32'(bus.bomb1_on), 32'd1);
      applyStimulus(0, 0, 300, 0, 600, 440);
      runFrames(110);
      applyStimulus(1, 0, 300, 0, 600, 440);
      runFrames(1);
      chk("s1_drop_in_cooldown", 32'(bus.bomb1_on), 32'd0);
      applyStimulus(0, 0, 300, 0, 600, 440);
      runFrames(1);
      applyStimulus(1, 0, 300, 0, 600, 440);
      runFrames(1);
      chk("s1_drop_after_idle", 32'(bus.bomb1_on), 32'd1);

      $display("[TB] simultaneous drops and round-robin");
      doReset();
      applyStimulus(0, 0, 100, 100, 500, 300);
      runFrames(4);
      applyStimulus(1, 1, 100, 100, 500, 300);
      runFrames(1);
      applyStimulus(1, 1, 600, 440, 0, 0);
      runFrames(80);
      runFrames(1);
      chk("s2_p2_still_pending", 32'(bus.bomb2_on), 32'd1);
      chk("s2_gap_frame", 32'(bus.blast_on), 32'd0);
      runFrames(1);
      chk("s2_p2_blast", 32'(bus.blast_on), 32'd1);
      chk("s2_p2_owner", 32'(bus.blast_owner), 32'd1);
      applyStimulus(0, 0, 600, 440, 0, 0);
      runFrames(53);
      applyStimulus(1, 1, 100, 100, 500, 300);
      runFrames(1);
      applyStimulus(1, 1, 600, 440, 0, 0);
      runFrames(60);
      chk("s2_repeat_wait", 32'(bus.blast_on), 32'd0);
      runFrames(1);
      chk("s2_repeat_p2_first", 32'(bus.blast_owner), 32'd1);
      chk("s2_repeat_blast_on", 32'(bus.blast_on), 32'd1);
      runFrames(30);

      $display("[TB] chain reaction");
      doReset();
      applyStimulus(0, 0, 200, 200, 0, 0);
      runFrames(4);
      applyStimulus(1, 0, 200, 200, 0, 0);
      runFrames(1);
      applyStimulus(1, 0, 600, 440, 0, 0);
      runFrames(29);
      applyStimulus(1, 1, 600, 440, 220, 200);
      runFrames(1);
      applyStimulus(1, 1, 600, 440, 0, 0);
      runFrames(31);
      chk("s3_p1_owner", 32'(bus.blast_owner), 32'd0);
      runFrames(20);
      chk("s3_p1_done", 32'(bus.blast_on), 32'd0);
      runFrames(1);
      chk("s3_chain_blast", 32'(bus.blast_on), 32'd1);
      chk("s3_chain_owner", 32'(bus.blast_owner), 32'd1);
      chk("s3_chain_x0", 32'(bus.blastX0), 32'd196);
      runFrames(60);

      $display("[TB] blast box saturation and clamping");
      doReset();
      applyStimulus(0, 0, 0, 0, 630, 470);
      runFrames(1);
      applyStimulus(1, 1, 0, 0, 630, 470);
      runFrames(1);
      applyStimulus(1, 1, 300, 0, 300, 200);
      runFrames(61);
      chk("s4_x0_sat", 32'(bus.blastX0), 32'd0);
      chk("s4_y0_sat", 32'(bus.blastY0), 32'd0);
      chk("s4_x1", 32'(bus.blastX1), 32'd39);
      runFrames(21);
      chk("s4_x1_clamp", 32'(bus.blastX1), 32'd639);
      chk("s4_y1_clamp", 32'(bus.blastY1), 32'd479);
      chk("s4_x0_far", 32'(bus.blastX0), 32'd606);
      runFrames(40);

      $display("[TB] random drops and positions");
      doReset();
      rx1 = 200; ry1 = 200; rx2 = 240; ry2 = 220;
      repeat (600) begin
         if ($urandom_range(0, 7) == 0) begin
            rx1 = $urandom_range(180, 320); ry1 = $urandom_range(180, 300);
         end
         if ($urandom_range(0, 7) == 0) begin
            rx2 = $urandom_range(180, 320); ry2 = $urandom_range(180, 300);
         end
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, rx1, ry1, rx2, ry2);
         runFrames(1);
      end

      $display("[TB] three hits end the game");
      doReset();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 0, 310, 300, 300, 300);
         runFrames(1);
         applyStimulus(0, 0, 600, 440, 300, 300);
         runFrames(119);
      end
      chk("s6_heart2_zero", 32'(bus.heart2), 32'd0);
      chk("s6_game_over", 32'(bus.game_over), 32'd1);
      chk("s6_heart1_intact", 32'(bus.heart1), 32'd3);
      applyStimulus(1, 0, 310, 300, 300, 300);
      runFrames(1);
      chk("s6_drop_ignored", 32'(bus.bomb1_on), 32'd0);
      runFrames(5);

      $display("[TB] reset during a blast");
      doReset();
      applyStimulus(1, 0, 100, 200, 110, 210);
      runFrames(1);
      applyStimulus(0, 0, 600, 440, 110, 210);
      runFrames(62);
      chk("s7_blast_before_reset", 32'(bus.blast_on), 32'd1);
      #2;
      Reset = 1'b0;
      #1;
      chk("s7_blast_aborted", 32'(bus.blast_on), 32'd0);
      chk("s7_heart1", 32'(bus.heart1), 32'd3);
      chk("s7_heart2", 32'(bus.heart2), 32'd3);
      modelReset();
      checkOutput();
      @(negedge frame_clk);
      Reset = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
